// File: rtl/bp_unit_pkg.sv
// bp_unit_pkg: shared widths, PHT state encodings and counter step helper
package bp_unit_pkg;
    localparam int PcWidth        = 32;
    localparam int PhtStateWidth  = 2;
    localparam int PrToIfBusWidth = 37;
    localparam int BP_INFO_WIDTH  = 36;
    typedef enum logic [PhtStateWidth-1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } pht_state_e;
    localparam pht_state_e PHT_RESET = WNT;
    function automatic pht_state_e pht_next(pht_state_e s, logic taken);
        return taken ? (s == ST ? ST : pht_state_e'(s + 2'd1))
                     : (s == SNT ? SNT : pht_state_e'(s - 2'd1));
    endfunction
endpackage

// File: rtl/bp_btb.sv
// bp_btb: direct-mapped branch target buffer, async read, one write port
module bp_btb #(
    parameter int IDX_W  = 6,
    parameter int TAG_W  = 24,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [TAG_W-1:0]  rd_tag,
    output logic              rd_hit,
    output logic [DATA_W-1:0] rd_target,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [DATA_W-1:0] wr_target
);
    import bp_unit_pkg::*;
    logic [2**IDX_W-1:0] valid;
    logic [TAG_W-1:0]    tags    [2**IDX_W];
    logic [DATA_W-1:0]   targets [2**IDX_W];
    // combinational read: hit needs a valid entry with a matching tag
    always_comb begin
        rd_hit    = valid[rd_idx] && tags[rd_idx] == rd_tag;
        rd_target = targets[rd_idx];
    end
    // only valid bits are cleared; stale tags/targets stay hidden behind them
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) valid <= '0;
        else if (wr_en) valid[wr_idx] <= 1'b1;
    // a new taken branch simply replaces whatever lives at its index
    always_ff @(posedge clk)
        if (wr_en) begin
            tags[wr_idx]    <= wr_tag;
            targets[wr_idx] <= wr_target;
        end
endmodule

// File: rtl/bp_unit.sv
// bp_unit: bimodal predictor with 2-bit PHT, direct-mapped BTB and stat counters
module bp_unit #(
    parameter int PcWidth   = 32,
    parameter int PHT_IDX_W = 8,
    parameter int BTB_IDX_W = 6,
    parameter int BTB_TAG_W = PcWidth - 2 - BTB_IDX_W
) (
    input  logic                                    clk,
    input  logic                                    resetn,
    input  logic [PcWidth-1:0]                      bp_pc_i,
    output logic [bp_unit_pkg::PrToIfBusWidth-1:0]  bp_to_if_bus,
    input  logic                                    upd_valid,
    input  logic [PcWidth-1:0]                      upd_pc,
    input  logic                                    upd_taken,
    input  logic [PcWidth-1:0]                      upd_target,
    input  logic                                    upd_pred_taken,
    input  logic [PcWidth-1:0]                      upd_pred_target,
    input  logic                                    upd_pred_hit,
    output logic [31:0]                             branch_cnt,
    output logic [31:0]                             mispred_cnt
);
    import bp_unit_pkg::*;
    pht_state_e         pht [2**PHT_IDX_W];
    pht_state_e         rd_state;
    logic               btb_hit;
    logic [PcWidth-1:0] btb_target;
    logic               mispred;
    logic               unused;
    assign unused = ^upd_pc[1:0];
    bp_btb #(.IDX_W(BTB_IDX_W), .TAG_W(BTB_TAG_W), .DATA_W(PcWidth)) u_btb (
        .clk       (clk),
        .resetn    (resetn),
        .rd_idx    (bp_pc_i[BTB_IDX_W+1:2]),
        .rd_tag    (bp_pc_i[PcWidth-1:BTB_IDX_W+2]),
        .rd_hit    (btb_hit),
        .rd_target (btb_target),
        .wr_en     (upd_valid && upd_taken),
        .wr_idx    (upd_pc[BTB_IDX_W+1:2]),
        .wr_tag    (upd_pc[PcWidth-1:BTB_IDX_W+2]),
        .wr_target (upd_target)
    );
    // same-cycle lookup; falls through to pc+4 on a BTB miss
    always_comb begin
        rd_state     = pht[bp_pc_i[PHT_IDX_W+1:2]];
        bp_to_if_bus = {bp_pc_i[1:0] == 2'b00, rd_state[1], rd_state, btb_hit,
                        btb_hit ? btb_target : bp_pc_i + PcWidth'(4)};
    end
    // direction wrong, or taken with a missing/wrong target
    always_comb
        mispred = upd_valid && (upd_pred_taken != upd_taken ||
                  (upd_taken && (!upd_pred_hit || upd_pred_target != upd_target)));
    // PHT read-modify-write uses the current entry; counters step alongside
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            for (int i = 0; i < 2**PHT_IDX_W; i++) pht[i] <= PHT_RESET;
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (upd_valid) pht[upd_pc[PHT_IDX_W+1:2]] <= pht_next(pht[upd_pc[PHT_IDX_W+1:2]], upd_taken);
            branch_cnt  <= branch_cnt + 32'(upd_valid);
            mispred_cnt <= mispred_cnt + 32'(mispred);
        end
endmodule

// File: tb/tb_bp_unit.sv
// tb_bp_unit: directed plus randomized checks against a table-level reference model
module tb_bp_unit;
    logic        clk = 0;
    logic        resetn = 0;
    logic [31:0] bp_pc_i = 0;
    logic [36:0] bp_to_if_bus;
    logic        upd_valid = 0, upd_taken = 0, upd_pred_taken = 0, upd_pred_hit = 0;
    logic [31:0] upd_pc = 0, upd_target = 0, upd_pred_target = 0;
    logic [31:0] branch_cnt, mispred_cnt;
    int          checks = 0, failures = 0;
    int          m_pht [256];
    bit          m_v   [64];
    logic [23:0] m_tag [64];
    logic [31:0] m_tgt [64];
    int unsigned m_br, m_mp;

    bp_unit dut (
        .clk(clk), .resetn(resetn), .bp_pc_i(bp_pc_i), .bp_to_if_bus(bp_to_if_bus),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .upd_pred_hit(upd_pred_hit), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 256; i++) m_pht[i] = 1;
        for (int i = 0; i < 64; i++) m_v[i] = 0;
        m_br = 0;
        m_mp = 0;
    endfunction

    function automatic logic [36:0] model_bus(input logic [31:0] pc);
        int pi = int'(pc[9:2]);
        int bi = int'(pc[7:2]);
        bit hit = m_v[bi] && m_tag[bi] == pc[31:8];
        logic [1:0] st = 2'(m_pht[pi]);
        return {pc[1:0] == 2'b00, m_pht[pi] >= 2, st, hit, hit ? m_tgt[bi] : pc + 32'd4};
    endfunction

    function automatic void model_apply(input logic [31:0] pc, input bit t, input logic [31:0] tgt,
                                        input bit pt, input bit ph, input logic [31:0] ptgt);
        int pi = int'(pc[9:2]);
        int bi = int'(pc[7:2]);
        m_br++;
        if (pt != t || (t && (!ph || ptgt != tgt))) m_mp++;
        m_pht[pi] = t ? (m_pht[pi] < 3 ? m_pht[pi] + 1 : 3) : (m_pht[pi] > 0 ? m_pht[pi] - 1 : 0);
        if (t) begin
            m_v[bi] = 1;
            m_tag[bi] = pc[31:8];
            m_tgt[bi] = tgt;
        end
    endfunction

    task automatic step(input logic [31:0] pc, input bit v, input logic [31:0] upc, input bit t,
                        input logic [31:0] tgt, input bit pt, input bit ph, input logic [31:0] ptgt);
        @(negedge clk);
        bp_pc_i = pc; upd_valid = v; upd_pc = upc; upd_taken = t; upd_target = tgt;
        upd_pred_taken = pt; upd_pred_hit = ph; upd_pred_target = ptgt;
        #1 check("bus", 64'(bp_to_if_bus), 64'(model_bus(pc)));
        @(posedge clk);
        if (v) model_apply(upc, t, tgt, pt, ph, ptgt);
        #1;
        check("branch_cnt", 64'(branch_cnt), 64'(m_br));
        check("mispred_cnt", 64'(mispred_cnt), 64'(m_mp));
    endtask

    task automatic upd(input logic [31:0] upc, input bit t, input logic [31:0] tgt,
                       input bit pt, input bit ph, input logic [31:0] ptgt);
        step(upc, 1, upc, t, tgt, pt, ph, ptgt);
    endtask

    task automatic look(input logic [31:0] pc);
        @(negedge clk);
        bp_pc_i = pc;
        upd_valid = 0;
        #1;
    endtask

    initial begin
        logic [31:0] pc, upc, tgt, ptgt;
        logic [36:0] pred;
        bit t, pt, ph;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) resetn = 1;
        look(32'h1c000000);
        check("reset_bus", 64'(bp_to_if_bus), 64'({1'b1, 1'b0, 2'b01, 1'b0, 32'h1c000004}));
        check("reset_branch_cnt", 64'(branch_cnt), 64'd0);
        check("reset_mispred_cnt", 64'(mispred_cnt), 64'd0);
        upd(32'h1c000010, 1, 32'h1c000100, 0, 0, 32'h1c000014);
        look(32'h1c000010);
        check("train1_bus", 64'(bp_to_if_bus), 64'({1'b1, 1'b1, 2'b10, 1'b1, 32'h1c000100}));
        upd(32'h1c000010, 1, 32'h1c000100, 1, 1, 32'h1c000100);
        look(32'h1c000010);
        check("train2_state", 64'(bp_to_if_bus[34:33]), 64'(2'b11));
        check("train_branch_cnt", 64'(branch_cnt), 64'd2);
        check("train_mispred_cnt", 64'(mispred_cnt), 64'd1);
        for (int i = 0; i < 3; i++) begin
            upd(32'h1c000010, 1, 32'h1c000100, 1, 1, 32'h1c000100);
            look(32'h1c000010);
            check("sat_taken_state", 64'(bp_to_if_bus[34:33]), 64'(2'b11));
            check("sat_taken_hit", 64'(bp_to_if_bus[32]), 64'd1);
        end
        for (int i = 0; i < 3; i++) begin
            upd(32'h1c000010, 0, 32'h0, 1, 1, 32'h1c000100);
            look(32'h1c000010);
            check("sat_nt_state", 64'(bp_to_if_bus[34:33]), 64'(2 - i));
            check("sat_nt_hit", 64'(bp_to_if_bus[32]), 64'd1);
        end
        upd(32'h1c000110, 1, 32'h1c000200, 0, 0, 32'h1c000114);
        look(32'h1c000010);
        check("alias_evicted_hit", 64'(bp_to_if_bus[32]), 64'd0);
        check("alias_evicted_tgt", 64'(bp_to_if_bus[31:0]), 64'h1c000014);
        look(32'h1c000110);
        check("alias_new_hit", 64'(bp_to_if_bus[32]), 64'd1);
        check("alias_new_tgt", 64'(bp_to_if_bus[31:0]), 64'h1c000200);
        @(negedge clk);
        bp_pc_i = 32'h1c000020; upd_valid = 1; upd_pc = 32'h1c000020; upd_taken = 1;
        upd_target = 32'h1c000300; upd_pred_taken = 0; upd_pred_hit = 0; upd_pred_target = 32'h1c000024;
        #1 check("collide_same_cycle", 64'(bp_to_if_bus[34:33]), 64'(2'b01));
        @(posedge clk);
        model_apply(32'h1c000020, 1, 32'h1c000300, 0, 0, 32'h1c000024);
        #1 check("collide_next_cycle", 64'(bp_to_if_bus[34:33]), 64'(2'b10));
        @(negedge clk);
        bp_pc_i = 32'h1c000010; upd_pc = 32'h1c000030; upd_target = 32'h1c000400;
        #2 resetn = 0;
        #1;
        check("midrst_bus", 64'(bp_to_if_bus), 64'({1'b1, 1'b0, 2'b01, 1'b0, 32'h1c000014}));
        check("midrst_branch_cnt", 64'(branch_cnt), 64'd0);
        check("midrst_mispred_cnt", 64'(mispred_cnt), 64'd0);
        @(posedge clk);
        @(negedge clk);
        upd_valid = 0;
        resetn = 1;
        model_reset();
        look(32'h1c000030);
        check("post_rst_bus", 64'(bp_to_if_bus), 64'({1'b1, 1'b0, 2'b01, 1'b0, 32'h1c000034}));
        look(32'h1c000020);
        check("post_rst_state", 64'(bp_to_if_bus[34:33]), 64'(2'b01));
        check("post_rst_branch_cnt", 64'(branch_cnt), 64'd0);
        look(32'h1c000002);
        check("misaligned_valid", 64'(bp_to_if_bus[36]), 64'd0);
        for (int i = 0; i < 1500; i++) begin
            pc  = 32'h1c000000 + ($urandom_range(0, 511) << 2) + (($urandom_range(0, 15) == 0) ? 32'd2 : 32'd0);
            upc = 32'h1c000000 + ($urandom_range(0, 511) << 2);
            tgt = 32'h1c000000 + ($urandom_range(0, 7) << 4);
            t   = $urandom_range(0, 99) < 60;
            pred = model_bus(upc);
            pt   = pred[35] ^ ($urandom_range(0, 9) == 0);
            ph   = pred[32] ^ ($urandom_range(0, 9) == 0);
            ptgt = ($urandom_range(0, 9) == 0) ? $urandom : pred[31:0];
            step(pc, $urandom_range(0, 3) != 0, upc, t, tgt, pt, ph, ptgt);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
